// File: rtl/sine_voice_scheduler.sv
// Voice allocator and round-robin phase sequencer feeding the shared sine pipeline.
// Each enabled cycle issues one voice slot; note events are resolved by a
// scan FSM that walks every voice once, then commits in a single cycle.
module sine_voice_scheduler #(
    parameter int NVOICES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        i_ev_valid,
    output logic        o_ev_ready,
    input  logic        i_ev_on,
    input  logic [6:0]  i_ev_midi,
    input  logic [23:0] i_ev_inc,
    output logic        o_valid,
    output logic [23:0] o_phase,
    output logic [6:0]  o_midi,
    output logic [3:0]  o_slot,
    output logic        o_drop
);

    localparam logic [3:0] LAST = 4'(NVOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    typedef struct packed {
        logic        on;
        logic [6:0]  midi;
        logic [23:0] inc;
    } ev_t;

    logic [NVOICES-1:0] active;
    logic [23:0]        acc  [NVOICES];
    logic [23:0]        inc  [NVOICES];
    logic [6:0]         midi [NVOICES];

    state_t      state;
    ev_t         ev;
    logic [3:0]  slot;
    logic [3:0]  k;
    logic        match_found;
    logic [3:0]  match_idx;
    logic        free_found;
    logic [3:0]  free_idx;

    assign o_ev_ready = (state == IDLE);

    // Slot issue, accumulation and event FSM share one register block so the
    // commit write can simply land after (and override) the accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NVOICES; v++) begin
                acc[v]  <= '0;
                inc[v]  <= '0;
                midi[v] <= '0;
            end
            active      <= '0;
            state       <= IDLE;
            ev          <= '0;
            slot        <= '0;
            k           <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            o_valid     <= 1'b0;
            o_phase     <= '0;
            o_midi      <= '0;
            o_slot      <= '0;
            o_drop      <= 1'b0;
        end else if (clk_en) begin
            // issue the current slot from pre-update voice state
            o_slot  <= slot;
            o_valid <= active[slot];
            o_phase <= active[slot] ? acc[slot]  : '0;
            o_midi  <= active[slot] ? midi[slot] : '0;
            o_drop  <= 1'b0;
            if (active[slot])
                acc[slot] <= acc[slot] + inc[slot];
            slot <= (slot == LAST) ? 4'd0 : slot + 4'd1;

            case (state)
                IDLE: begin
                    if (i_ev_valid) begin
                        ev          <= '{on: i_ev_on, midi: i_ev_midi, inc: i_ev_inc};
                        k           <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    // first hit wins: lowest matching / lowest free index
                    if (active[k] && midi[k] == ev.midi && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= k;
                    end
                    if (!active[k] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= k;
                    end
                    if (k == LAST) state <= COMMIT;
                    else           k     <= k + 4'd1;
                end
                COMMIT: begin
                    if (ev.on) begin
                        if (match_found) begin
                            acc[match_idx] <= '0;
                            inc[match_idx] <= ev.inc;
                        end else if (free_found) begin
                            active[free_idx] <= 1'b1;
                            midi[free_idx]   <= ev.midi;
                            acc[free_idx]    <= '0;
                            inc[free_idx]    <= ev.inc;
                        end else begin
                            o_drop <= 1'b1;
                        end
                    end else if (match_found) begin
                        active[match_idx] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
